// File: rtl/cv_accel_pkg.sv
// Shared definitions for the convolution accelerator blocks: streamer state
// encoding and default datapath widths.
package cv_accel_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } cv_state_t;

   localparam int DEF_WEIGHTS_IN_ROW = 64;
   localparam int DEF_WEIGHT_BITS    = 8;
   localparam int DEF_DEPTH          = 2048;
   localparam int DEF_REPEAT_W       = 8;

endpackage

// File: rtl/cv_weights_stream_if.sv
// Bundle of the streamer's configuration, consumer, loader and output signals.
// master = driver side (sequencer/loader/PE array model), slave = streamer.
interface cv_weights_stream_if #(
   parameter int ADDR_W   = 11,
   parameter int ROW_W    = 512,
   parameter int REPEAT_W = 8
);
   logic                cfg_start;
   logic [ADDR_W-1:0]   cfg_base;
   logic [ADDR_W:0]     cfg_len;
   logic [REPEAT_W-1:0] cfg_repeat;
   logic                re_fm_en;
   logic                re_fm_end;
   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic [ROW_W-1:0]    wr_data;
   logic                busy;
   logic                done;
   logic                weights_valid;
   logic [ROW_W-1:0]    weights_vector;

   modport master (
      output cfg_start, cfg_base, cfg_len, cfg_repeat,
      output re_fm_en, re_fm_end,
      output wr_en, wr_addr, wr_data,
      input  busy, done, weights_valid, weights_vector
   );

   modport slave (
      input  cfg_start, cfg_base, cfg_len, cfg_repeat,
      input  re_fm_en, re_fm_end,
      input  wr_en, wr_addr, wr_data,
      output busy, done, weights_valid, weights_vector
   );
endinterface

// File: rtl/cv_weights_stream_ram.sv
// Weight store: one write port, one registered read port, read-first.
// Only the output register is reset; array contents survive reset.
module weights_ram #(
   parameter int ROW_W  = 512,
   parameter int DEPTH  = 2048,
   parameter int ADDR_W = 11
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [ROW_W-1:0]  i_wr_data,
   input  logic              i_rd_en,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [ROW_W-1:0]  o_rd_data
);
   logic [ROW_W-1:0] r_mem [DEPTH];
   logic [ROW_W-1:0] r_rd_data;

   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
   end

   // Same-edge read samples the array before the write lands: old data out.
   always_ff @(posedge clk) begin
      if (reset)        r_rd_data <= '0;
      else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rd_data = r_rd_data;
endmodule

// File: rtl/cv_weights_stream.sv
// Weight-row streamer: replays a window of stored rows for a number of passes,
// one row per consumer advance, with start/done handshake and restart.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | waiting for cfg_start; config latched on acceptance
// ST_RUN  | issuing rows on re_fm_en; re_fm_end rewinds the pass
// ST_DONE | one-cycle done pulse after the last row of the final pass
module cv_weights_stream
   import cv_accel_pkg::*;
#(
   parameter int WEIGHTS_IN_ROW = DEF_WEIGHTS_IN_ROW,
   parameter int WEIGHT_BITS    = DEF_WEIGHT_BITS,
   parameter int ROW_W          = WEIGHTS_IN_ROW * WEIGHT_BITS,
   parameter int DEPTH          = DEF_DEPTH,
   parameter int ADDR_W         = $clog2(DEPTH),
   parameter int REPEAT_W       = DEF_REPEAT_W
) (
   input logic               clk,
   input logic               reset,
   cv_weights_stream_if.slave bus
);
   localparam logic [ADDR_W:0]     LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [REPEAT_W-1:0] REP_ONE = {{(REPEAT_W-1){1'b0}}, 1'b1};

   cv_state_t           r_state, w_state_nxt;
   logic [ADDR_W-1:0]   r_base;
   logic [ADDR_W:0]     r_len;
   logic [REPEAT_W-1:0] r_rep;
   logic [ADDR_W:0]     r_off, w_off_nxt;
   logic [REPEAT_W-1:0] r_pass, w_pass_nxt;
   logic                r_valid;
   logic                w_rd_en;
   logic [ADDR_W-1:0]   w_rd_addr;
   logic [ADDR_W:0]     w_last_off;
   logic [REPEAT_W-1:0] w_last_pass;
   logic                w_accept;

   assign w_accept    = (r_state == ST_IDLE) && bus.cfg_start;
   assign w_last_off  = r_len - LEN_ONE;
   assign w_last_pass = r_rep - REP_ONE;
   // Window wraps modulo DEPTH through the ADDR_W-bit add.
   assign w_rd_addr   = r_base + r_off[ADDR_W-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_off   <= '0;
         r_pass  <= '0;
         r_base  <= '0;
         r_len   <= '0;
         r_rep   <= REP_ONE;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_off   <= w_off_nxt;
         r_pass  <= w_pass_nxt;
         r_valid <= w_rd_en;
         if (w_accept) begin
            r_base <= bus.cfg_base;
            r_len  <= bus.cfg_len;
            r_rep  <= (bus.cfg_repeat == '0) ? REP_ONE : bus.cfg_repeat;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_off_nxt   = r_off;
      w_pass_nxt  = r_pass;
      w_rd_en     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.cfg_start) begin
               w_off_nxt   = '0;
               w_pass_nxt  = '0;
               w_state_nxt = (bus.cfg_len == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (bus.re_fm_en) begin
               if (bus.re_fm_end) begin
                  w_off_nxt = '0;
               end else begin
                  w_rd_en = 1'b1;
                  if (r_off == w_last_off) begin
                     w_off_nxt  = '0;
                     w_pass_nxt = r_pass + REP_ONE;
                     if (r_pass == w_last_pass) w_state_nxt = ST_DONE;
                  end else begin
                     w_off_nxt = r_off + LEN_ONE;
                  end
               end
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   weights_ram #(
      .ROW_W  (ROW_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk       (clk),
      .reset     (reset),
      .i_wr_en   (bus.wr_en),
      .i_wr_addr (bus.wr_addr),
      .i_wr_data (bus.wr_data),
      .i_rd_en   (w_rd_en),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (bus.weights_vector)
   );

   assign bus.busy          = (r_state == ST_RUN) || (r_state == ST_DONE);
   assign bus.done          = (r_state == ST_DONE);
   assign bus.weights_valid = r_valid;
endmodule
